am2940_data_port: RTL and testbench

AM2940_DATA_PORT -- requirements
Module: am2940_data_port

---
 rtl/am2940_data_port_if.sv | 33 +++
 rtl/am2940_data_port.sv | 166 ++++++++++++++++
 tb/tb_am2940_data_port.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/am2940_data_port_if.sv
// Host-side register-access bus of the Am2940 data port: request, beat data and status.
// The host drives the master side; the data port sits on the slave side.
interface am2940_data_port_if #(
   parameter int BUS_W = 4,
   parameter int CHW   = 1
);
   // Handshake: req is sampled only while the port is idle and not busy. Write
   // beats after the first are accepted on cycles with in_valid=1. Each read
   // beat is qualified by data_valid. done/err are single-cycle pulses.
   logic             req;
   logic             rd;
   logic             wr;
   logic [1:0]       seld;
   logic [CHW-1:0]   ch;
   logic [BUS_W-1:0] data_in;
   logic             in_valid;
   logic             abort;
   logic [BUS_W-1:0] data_out;
   logic             data_valid;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output req, rd, wr, seld, ch, data_in, in_valid, abort,
      input  data_out, data_valid, busy, done, err
   );

   modport slave (
      input  req, rd, wr, seld, ch, data_in, in_valid, abort,
      output data_out, data_valid, busy, done, err
   );
endinterface

// File: rtl/am2940_data_port.sv
// Narrow-bus access port to per-channel address/word-count counters and control
// registers: reads serialise a snapshotted word LSB-first, writes assemble beats.
module am2940_data_port #(
   parameter int BUS_W  = 4,
   parameter int REG_W  = 8,
   parameter int NCH    = 2,
   parameter int CTRL_W = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   am2940_data_port_if.slave       bus,
   input  logic [NCH*REG_W-1:0]    address_data,
   input  logic [NCH*REG_W-1:0]    word_data,
   output logic [NCH-1:0]          ld_addr,
   output logic [NCH-1:0]          ld_word,
   output logic [REG_W-1:0]        ld_value,
   output logic [NCH*CTRL_W-1:0]   ctrl_reg,
   output logic [1:0]              fsm_state
);
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int BEATS = REG_W / BUS_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   // Bit i set when channel code i exists; avoids a compare that is constant for power-of-two NCH.
   localparam logic [(1<<CHW)-1:0] CH_MASK = (1<<CHW)'((64'd1 << NCH) - 64'd1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RD_SHIFT   = 2'd1,
      WR_COLLECT = 2'd2
   } state_t;

   state_t             state_q;
   logic [REG_W-1:0]   shift_q;
   logic [REG_W-1:0]   asm_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               wr_word_q;
   logic [CHW-1:0]     wr_ch_q;

   logic               ch_ok;
   logic               req_ok;
   logic [REG_W-1:0]   rd_value;
   logic [BUS_W-1:0]   ctrl_beat;
   logic [REG_W-1:0]   asm_next;
   logic               last_beat;

   assign fsm_state = state_q;
   assign ch_ok     = CH_MASK[bus.ch];
   assign req_ok    = ch_ok && (bus.rd != bus.wr);
   assign rd_value  = bus.seld[0] ? word_data[int'(bus.ch)*REG_W +: REG_W]
                                  : address_data[int'(bus.ch)*REG_W +: REG_W];
   assign ctrl_beat = BUS_W'(ctrl_reg[int'(bus.ch)*CTRL_W +: CTRL_W]);
   // New beats enter at the top; after BEATS shifts the first beat sits in the LSBs.
   assign asm_next  = (asm_q >> BUS_W) | (REG_W'(bus.data_in) << (REG_W - BUS_W));
   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         shift_q        <= '0;
         asm_q          <= '0;
         cnt_q          <= '0;
         wr_word_q      <= 1'b0;
         wr_ch_q        <= '0;
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
         ld_addr        <= '0;
         ld_word        <= '0;
         ld_value       <= '0;
         ctrl_reg       <= '0;
      end else begin
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
         ld_addr        <= '0;
         ld_word        <= '0;
         ld_value       <= '0;

         case (state_q)
            IDLE: begin
               bus.busy <= 1'b0;
               // busy is still high on the done cycle, so a request there is ignored.
               if (bus.req && !bus.busy) begin
                  if (!req_ok) begin
                     bus.err <= 1'b1;
                  end else if (bus.rd) begin
                     bus.busy       <= 1'b1;
                     bus.data_valid <= 1'b1;
                     if (bus.seld[1]) begin
                        bus.data_out <= ctrl_beat;
                        bus.done     <= 1'b1;
                     end else begin
                        bus.data_out <= rd_value[BUS_W-1:0];
                        shift_q      <= rd_value >> BUS_W;
                        cnt_q        <= CNT_W'(1);
                        if (BEATS == 1) bus.done <= 1'b1;
                        else            state_q  <= RD_SHIFT;
                     end
                  end else begin
                     bus.busy <= 1'b1;
                     if (bus.seld[1]) begin
                        ctrl_reg[int'(bus.ch)*CTRL_W +: CTRL_W] <= bus.data_in[CTRL_W-1:0];
                        bus.done <= 1'b1;
                     end else begin
                        wr_word_q <= bus.seld[0];
                        wr_ch_q   <= bus.ch;
                        asm_q     <= asm_next;
                        cnt_q     <= CNT_W'(1);
                        if (BEATS == 1) begin
                           if (bus.seld[0]) ld_word <= NCH'(1) << bus.ch;
                           else             ld_addr <= NCH'(1) << bus.ch;
                           ld_value <= asm_next;
                           bus.done <= 1'b1;
                        end else begin
                           state_q <= WR_COLLECT;
                        end
                     end
                  end
               end
            end

            RD_SHIFT: begin
               if (bus.abort) begin
                  state_q  <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  bus.data_valid <= 1'b1;
                  bus.data_out   <= shift_q[BUS_W-1:0];
                  shift_q        <= shift_q >> BUS_W;
                  cnt_q          <= cnt_q + CNT_W'(1);
                  if (last_beat) begin
                     bus.done <= 1'b1;
                     state_q  <= IDLE;
                  end
               end
            end

            WR_COLLECT: begin
               // abort wins even over the beat that would complete the word.
               if (bus.abort) begin
                  state_q  <= IDLE;
                  bus.busy <= 1'b0;
               end else if (bus.in_valid) begin
                  asm_q <= asm_next;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_beat) begin
                     if (wr_word_q) ld_word <= NCH'(1) << wr_ch_q;
                     else           ld_addr <= NCH'(1) << wr_ch_q;
                     ld_value <= asm_next;
                     bus.done <= 1'b1;
                     state_q  <= IDLE;
                  end
               end
            end

            default: begin
               state_q  <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_am2940_data_port.sv
// Cycle-by-cycle vector bench for am2940_data_port (BUS_W=4, REG_W=8, NCH=2, CTRL_W=3),
// plus a three-channel instance for the out-of-range channel case.
module tb_am2940_data_port;
   localparam logic [15:0] A_DEF = 16'hA512;
   localparam logic [15:0] W_DEF = 16'h7E34;

   logic        clk;
   logic        rst_n;
   logic [15:0] address_data;
   logic [15:0] word_data;
   logic [1:0]  ld_addr;
   logic [1:0]  ld_word;
   logic [7:0]  ld_value;
   logic [5:0]  ctrl_reg;
   logic [1:0]  fsm_state;

   logic [23:0] address_data3;
   logic [23:0] word_data3;
   logic [2:0]  ld_addr3;
   logic [2:0]  ld_word3;
   logic [7:0]  ld_value3;
   logic [8:0]  ctrl_reg3;
   logic [1:0]  fsm_state3;

   int checks;
   int failures;

   am2940_data_port_if #(.BUS_W(4), .CHW(1)) bus ();
   am2940_data_port_if #(.BUS_W(4), .CHW(2)) bus3 ();

   am2940_data_port u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .address_data(address_data), .word_data(word_data),
      .ld_addr(ld_addr), .ld_word(ld_word), .ld_value(ld_value),
      .ctrl_reg(ctrl_reg), .fsm_state(fsm_state)
   );

   am2940_data_port #(.BUS_W(4), .REG_W(8), .NCH(3), .CTRL_W(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3),
      .address_data(address_data3), .word_data(word_data3),
      .ld_addr(ld_addr3), .ld_word(ld_word3), .ld_value(ld_value3),
      .ctrl_reg(ctrl_reg3), .fsm_state(fsm_state3)
   );

   // Clock and reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, req, rd, wr;
      logic [1:0]  seld;
      logic        ch;
      logic [3:0]  din;
      logic        iv, ab;
      logic [15:0] addr;
      logic [3:0]  e_dout;
      logic        e_dv, e_busy, e_done, e_err;
      logic [1:0]  e_lda, e_ldw;
      logic [7:0]  e_ldv;
      logic [5:0]  e_ctrl;
      logic [1:0]  e_st;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic r, q, rd_i, wr_i, input logic [1:0] sd, input logic c,
      input logic [3:0] d, input logic iv, ab, input logic [15:0] a,
      input logic [3:0] eo, input logic edv, eb, edn, eer,
      input logic [1:0] ela, elw, input logic [7:0] elv,
      input logic [5:0] ect, input logic [1:0] est);
      vec_t v;
      v.rst_n = r; v.req = q; v.rd = rd_i; v.wr = wr_i; v.seld = sd; v.ch = c;
      v.din = d; v.iv = iv; v.ab = ab; v.addr = a;
      v.e_dout = eo; v.e_dv = edv; v.e_busy = eb; v.e_done = edn; v.e_err = eer;
      v.e_lda = ela; v.e_ldw = elw; v.e_ldv = elv; v.e_ctrl = ect; v.e_st = est;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Driver: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
   task automatic apply(input vec_t v);
      @(negedge clk);
      rst_n        = v.rst_n;
      bus.req      = v.req;
      bus.rd       = v.rd;
      bus.wr       = v.wr;
      bus.seld     = v.seld;
      bus.ch       = v.ch;
      bus.data_in  = v.din;
      bus.in_valid = v.iv;
      bus.abort    = v.ab;
      address_data = v.addr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_vec(input vec_t v, input string tag);
      chk({tag, ".data_out"},   32'(bus.data_out),   32'(v.e_dout));
      chk({tag, ".data_valid"}, 32'(bus.data_valid), 32'(v.e_dv));
      chk({tag, ".busy"},       32'(bus.busy),       32'(v.e_busy));
      chk({tag, ".done"},       32'(bus.done),       32'(v.e_done));
      chk({tag, ".err"},        32'(bus.err),        32'(v.e_err));
      chk({tag, ".ld_addr"},    32'(ld_addr),        32'(v.e_lda));
      chk({tag, ".ld_word"},    32'(ld_word),        32'(v.e_ldw));
      chk({tag, ".ld_value"},   32'(ld_value),       32'(v.e_ldv));
      chk({tag, ".ctrl_reg"},   32'(ctrl_reg),       32'(v.e_ctrl));
      chk({tag, ".state"},      32'(fsm_state),      32'(v.e_st));
   endtask

   task automatic drive3(input logic q, rd_i, wr_i, input logic [1:0] sd,
                         input logic [1:0] c, input logic [3:0] d);
      @(negedge clk);
      bus3.req = q; bus3.rd = rd_i; bus3.wr = wr_i; bus3.seld = sd;
      bus3.ch = c; bus3.data_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.req = 0; bus.rd = 0; bus.wr = 0; bus.seld = 0; bus.ch = 0;
      bus.data_in = 0; bus.in_valid = 0; bus.abort = 0;
      bus3.req = 0; bus3.rd = 0; bus3.wr = 0; bus3.seld = 0; bus3.ch = 0;
      bus3.data_in = 0; bus3.in_valid = 0; bus3.abort = 0;
      address_data  = A_DEF;
      word_data     = W_DEF;
      address_data3 = 24'h00A512;
      word_data3    = 24'h007E34;

      //                 r q rd wr sd c din iv ab addr      dout dv b dn er lda ldw ldv   ctrl  st
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,0,0));
      // read address ch1 = A5; counter drops to 00 after acceptance
      vecs.push_back(mk(1,1,1,0,0,1,0,0,0,A_DEF,     5,1,1,0,0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,16'h0012,  4'hA,1,1,1,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,0,0));
      // write word count ch0: 3, two stalls, C
      vecs.push_back(mk(1,1,0,1,1,0,3,0,0,A_DEF,     0,0,1,0,0,0,0,0,0,2));
      vecs.push_back(mk(1,0,0,0,0,0,9,0,0,A_DEF,     0,0,1,0,0,0,0,0,0,2));
      vecs.push_back(mk(1,0,0,0,0,0,9,0,0,A_DEF,     0,0,1,0,0,0,0,0,0,2));
      vecs.push_back(mk(1,0,0,0,0,0,4'hC,1,0,A_DEF,  0,0,1,1,0,0,1,8'hC3,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,0,0));
      // control ch1 <= F, read back as 7
      vecs.push_back(mk(1,1,0,1,2,1,4'hF,0,0,A_DEF,  0,0,1,1,0,0,0,0,6'h38,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      vecs.push_back(mk(1,1,1,0,2,1,0,0,0,A_DEF,     7,1,1,1,0,0,0,0,6'h38,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      // malformed requests
      vecs.push_back(mk(1,1,1,1,0,0,0,0,0,A_DEF,     0,0,0,0,1,0,0,0,6'h38,0));
      vecs.push_back(mk(1,1,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,1,0,0,0,6'h38,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      // read word count ch0 = 34; control writes while busy are ignored
      vecs.push_back(mk(1,1,1,0,1,0,0,0,0,A_DEF,     4,1,1,0,0,0,0,0,6'h38,1));
      vecs.push_back(mk(1,1,0,1,2,0,7,0,0,A_DEF,     3,1,1,1,0,0,0,0,6'h38,0));
      vecs.push_back(mk(1,1,0,1,2,0,7,0,0,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      // abort in idle, then abort over the final write beat
      vecs.push_back(mk(1,0,0,0,0,0,0,0,1,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      vecs.push_back(mk(1,1,0,1,0,1,6,0,0,A_DEF,     0,0,1,0,0,0,0,0,6'h38,2));
      vecs.push_back(mk(1,0,0,0,0,0,9,1,1,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      // abort during read
      vecs.push_back(mk(1,1,1,0,0,0,0,0,0,A_DEF,     2,1,1,0,0,0,0,0,6'h38,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,1,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      // write address ch1 = 4B without stalls
      vecs.push_back(mk(1,1,0,1,0,1,4'hB,0,0,A_DEF,  0,0,1,0,0,0,0,0,6'h38,2));
      vecs.push_back(mk(1,0,0,0,0,0,4,1,0,A_DEF,     0,0,1,1,0,2,0,8'h4B,6'h38,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,6'h38,0));
      // reset during read, control registers cleared
      vecs.push_back(mk(1,1,1,0,0,1,0,0,0,A_DEF,     5,1,1,0,0,0,0,0,6'h38,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,2,1,0,0,0,A_DEF,     0,1,1,1,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,A_DEF,     0,0,0,0,0,0,0,0,0,0));

      foreach (vecs[i]) begin
         apply(vecs[i]);
         check_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Long stall: word count ch1 = E1 after five idle beats
      v = mk(1,1,0,1,1,1,1,0,0,A_DEF, 0,0,1,0,0,0,0,0,0,2);
      apply(v);
      check_vec(v, "stall_first");
      for (int k = 0; k < 5; k++) begin
         v = mk(1,0,0,0,0,0,4'(k + 6),0,0,A_DEF, 0,0,1,0,0,0,0,0,0,2);
         apply(v);
         check_vec(v, $sformatf("stall%0d", k));
      end
      v = mk(1,0,0,0,0,0,4'hE,1,0,A_DEF, 0,0,1,1,0,0,2,8'hE1,0,0);
      apply(v);
      check_vec(v, "stall_last");
      v = mk(1,0,0,0,0,0,0,0,0,A_DEF, 0,0,0,0,0,0,0,0,0,0);
      apply(v);
      check_vec(v, "stall_idle");

      // Three-channel instance: ch=3 is out of range, ch=2 is a real channel
      drive3(1, 1, 0, 2'b00, 2'd3, 4'h0);
      chk("ch3_err",        32'(bus3.err),        32'd1);
      chk("ch3_busy",       32'(bus3.busy),       32'd0);
      chk("ch3_valid",      32'(bus3.data_valid), 32'd0);
      chk("ch3_state",      32'(fsm_state3),      32'd0);
      drive3(1, 0, 1, 2'b10, 2'd3, 4'h5);
      chk("ch3_wr_err",     32'(bus3.err),        32'd1);
      chk("ch3_wr_ctrl",    32'(ctrl_reg3),       32'd0);
      chk("ch3_wr_strobes", 32'({ld_addr3, ld_word3}), 32'd0);
      drive3(1, 0, 1, 2'b10, 2'd2, 4'h5);
      chk("ch2_wr_done",    32'(bus3.done),       32'd1);
      chk("ch2_wr_ctrl",    32'(ctrl_reg3),       32'h140);
      drive3(0, 0, 0, 2'b00, 2'd0, 4'h0);
      chk("ch2_idle_busy",  32'(bus3.busy),       32'd0);
      drive3(1, 1, 0, 2'b10, 2'd2, 4'h0);
      chk("ch2_rd_data",    32'(bus3.data_out),   32'h5);
      chk("ch2_rd_valid",   32'(bus3.data_valid), 32'd1);
      chk("ch2_rd_done",    32'(bus3.done),       32'd1);
      drive3(1, 1, 0, 2'b00, 2'd2, 4'h0);
      chk("ch2_busy_ign",   32'(bus3.data_valid), 32'd0);
      drive3(0, 0, 0, 2'b00, 2'd0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
